multi_debounce: RTL and testbench
=================================

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, meaning the number of independent input channels (minimum 1).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser flop count per channel (minimum 2).
REQ-003 The block SHALL have parameter STABLE_CYCLES, default 16384, meaning the consecutive disagreeing samples required to change a clean output (minimum 2).
REQ-004 The block SHALL have parameter HOLD_CYCLES, default 50000000, meaning the cycles a clean output must stay high before hold is flagged (minimum 1).
REQ-005 The block SHALL have parameter RESET_LEVEL, default 0, meaning the reset value of every synchroniser stage and clean output (0 or 1).
REQ-006 Port clk, input, 1 bit: the single 50MHz clock; every flop SHALL be clocked on its rising edge.
REQ-007 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port bouncy_in, input, CHANNELS bits: asynchronous bouncy inputs, one per channel.
REQ-009 Port clean_out, output, CHANNELS bits: debounced level per channel, registered.
REQ-010 Port rise_pulse, output, CHANNELS bits: one-cycle pulse when the corresponding clean_out goes 0->1.
REQ-011 Port fall_pulse, output, CHANNELS bits: one-cycle pulse when the corresponding clean_out goes 1->0.
REQ-012 Port held, output, CHANNELS bits: level, high while clean_out has been 1 for at least HOLD_CYCLES cycles.
REQ-013 Port held_pulse, output, CHANNELS bits: one-cycle pulse on the cycle held rises.

Function
REQ-014 Each channel SHALL pass bouncy_in through a SYNC_STAGES-deep flop chain; only the last stage (sync) SHALL feed any other logic.
REQ-015 Each channel SHALL have a stability counter of width $clog2(STABLE_CYCLES+1) that never wraps.
REQ-016 On any cycle where sync equals clean_out, the channel's stability counter SHALL clear to 0.
REQ-017 On any cycle where sync differs from clean_out and the counter is below STABLE_CYCLES-1, the counter SHALL increment by 1.
REQ-018 On a cycle where sync differs from clean_out and the counter equals STABLE_CYCLES-1, clean_out SHALL take the value of sync on that edge, and the counter SHALL clear.
REQ-019 A single sample of sync equal to clean_out during counting SHALL restart the count from 0; glitches shorter than STABLE_CYCLES SHALL never reach clean_out.
REQ-020 Latency from a clean step on bouncy_in to clean_out SHALL be exactly SYNC_STAGES+STABLE_CYCLES rising edges.
REQ-021 rise_pulse and fall_pulse SHALL be registered and asserted on the same edge that clean_out changes, for exactly one cycle.
REQ-022 Each channel SHALL have a hold counter of width $clog2(HOLD_CYCLES+1) that clears whenever clean_out is 0 and increments each cycle clean_out is 1, saturating at HOLD_CYCLES.
REQ-023 held SHALL be 1 exactly when the hold counter equals HOLD_CYCLES; held_pulse SHALL be 1 only on the first such cycle.
REQ-024 A fall of clean_out SHALL deassert held on the same edge as fall_pulse.
REQ-025 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-026 While rst_n=0, all synchroniser stages and clean_out SHALL be RESET_LEVEL; all counters, rise_pulse, fall_pulse, held and held_pulse SHALL be 0, independent of clk.
REQ-027 Reset asserted mid-count or mid-hold SHALL discard the count; no pulse SHALL be emitted on reset entry or release.
REQ-028 After rst_n rises, an input already equal to RESET_LEVEL SHALL produce no pulse; an opposite input SHALL be treated as a normal change.

Verification (CHANNELS=4, SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=20, RESET_LEVEL=0)
REQ-029 Clean step ch0 0->1 at edge 0 -> clean_out[0]=1 and rise_pulse[0]=1 at edge 10, rise_pulse[0]=0 at edge 11.
REQ-030 ch1 toggles every 3 cycles for 40 cycles, then holds 1 -> no change during bouncing; clean_out[1] rises 10 edges after the last toggle.
REQ-031 ch2 high for 7 cycles, low for 1, high again -> count restarts; clean_out[2] rises 10 edges after the final rise, single rise_pulse.
REQ-032 ch3 held high -> held_pulse[3] one cycle, 20 cycles after clean_out[3] rose; release -> fall_pulse[3] and held[3]=0 on the same edge.
REQ-033 ch0 and ch2 step together -> both clean outputs and rise pulses change on the same edge.
REQ-034 rst_n pulsed low for 3 cycles mid-count on ch1 (counter=5), asynchronous to clk -> outputs 0 immediately; after release the full 10-edge latency applies again.

Source files
------------

// File: rtl/multi_debounce.sv
// Per-channel synchronise + debounce of bouncy inputs, with edge pulses and a long-press "held" flag.
// Every channel is independent; all outputs are registered.
module multi_debounce #(
   parameter int CHANNELS      = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 16384,
   parameter int HOLD_CYCLES   = 50000000,
   parameter bit RESET_LEVEL   = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] bouncy_in,
   output logic [CHANNELS-1:0] clean_out,
   output logic [CHANNELS-1:0] rise_pulse,
   output logic [CHANNELS-1:0] fall_pulse,
   output logic [CHANNELS-1:0] held,
   output logic [CHANNELS-1:0] held_pulse
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_CYCLES);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   sync;
      logic [SW-1:0]          stab_q, stab_d;
      logic [HW-1:0]          hold_q, hold_d;
      logic                   clean_q, clean_d;
      logic                   held_q, held_d;
      logic                   rise_q, fall_q, held_pulse_q;

      assign sync = sync_q[SYNC_STAGES-1];

      always_comb begin
         stab_d  = '0;
         clean_d = clean_q;
         if (sync != clean_q) begin
            if (stab_q == STABLE_LAST) begin
               clean_d = sync;
            end else begin
               stab_d = stab_q + 1'b1;
            end
         end
         // Counting only while high before and after this edge, so a fall drops held on the fall edge.
         hold_d = '0;
         if (clean_q && clean_d) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
         end
         held_d = (hold_d == HOLD_MAX);
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync_q       <= {SYNC_STAGES{RESET_LEVEL}};
            stab_q       <= '0;
            hold_q       <= '0;
            clean_q      <= RESET_LEVEL;
            held_q       <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            held_pulse_q <= 1'b0;
         end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], bouncy_in[c]};
            stab_q       <= stab_d;
            hold_q       <= hold_d;
            clean_q      <= clean_d;
            held_q       <= held_d;
            rise_q       <= clean_d & ~clean_q;
            fall_q       <= ~clean_d & clean_q;
            held_pulse_q <= held_d & ~held_q;
         end
      end

      assign clean_out[c]  = clean_q;
      assign rise_pulse[c] = rise_q;
      assign fall_pulse[c] = fall_q;
      assign held[c]       = held_q;
      assign held_pulse[c] = held_pulse_q;
   end

endmodule

// File: tb/tb_multi_debounce.sv
// Bench for multi_debounce: directed latency check, then random bouncing against a timestamp-based model.
module tb_multi_debounce;

   localparam int CH     = 4;
   localparam int SYNC   = 2;
   localparam int STABLE = 8;
   localparam int HOLD   = 20;
   localparam bit RL     = 1'b0;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CH-1:0] bouncy_in;
   logic [CH-1:0] clean_out, rise_pulse, fall_pulse, held, held_pulse;

   multi_debounce #(
      .CHANNELS(CH), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE),
      .HOLD_CYCLES(HOLD), .RESET_LEVEL(RL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bouncy_in(bouncy_in), .clean_out(clean_out),
      .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .held(held), .held_pulse(held_pulse)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a sample delay line plus per-channel timestamps of the last agreeing
   // sample and of the last rise; a change is accepted once STABLE disagreeing samples in a row arrive.
   logic [CH-1:0] in_hist[$];
   int            n = 0;
   int            last_agree[CH];
   int            rise_edge[CH];
   logic [CH-1:0] m_clean, m_rise, m_fall, m_held, m_hpulse;

   task automatic model_reset();
      in_hist.delete();
      for (int s = 0; s < SYNC; s++) in_hist.push_back({CH{RL}});
      m_clean  = {CH{RL}};
      m_rise   = '0;
      m_fall   = '0;
      m_held   = '0;
      m_hpulse = '0;
      for (int c = 0; c < CH; c++) begin
         last_agree[c] = n;
         rise_edge[c]  = n;
      end
   endtask

   task automatic model_edge();
      logic [CH-1:0] sv;
      logic          prev_held;
      n++;
      if (!rst_n) begin
         model_reset();
         return;
      end
      sv = in_hist.pop_front();
      in_hist.push_back(bouncy_in);
      for (int c = 0; c < CH; c++) begin
         prev_held   = m_held[c];
         m_rise[c]   = 1'b0;
         m_fall[c]   = 1'b0;
         if (sv[c] == m_clean[c]) begin
            last_agree[c] = n;
         end else if (n - last_agree[c] >= STABLE) begin
            m_clean[c]    = sv[c];
            last_agree[c] = n;
            m_rise[c]     = sv[c];
            m_fall[c]     = ~sv[c];
            if (sv[c]) rise_edge[c] = n;
         end
         m_held[c]   = m_clean[c] && !m_rise[c] && (n - rise_edge[c] >= HOLD);
         m_hpulse[c] = m_held[c] && !prev_held;
      end
   endtask

   task automatic check_outputs(input string where);
      check({where, ".clean"}, 32'(clean_out),  32'(m_clean));
      check({where, ".rise"},  32'(rise_pulse), 32'(m_rise));
      check({where, ".fall"},  32'(fall_pulse), 32'(m_fall));
      check({where, ".held"},  32'(held),       32'(m_held));
      check({where, ".hpls"},  32'(held_pulse), 32'(m_hpulse));
   endtask

   int remaining[CH];
   logic [CH-1:0] level;

   initial begin
      int lat;
      rst_n     = 1'b0;
      bouncy_in = '0;
      #1;
      check("rst.clean", 32'(clean_out), 32'(0));
      check("rst.held",  32'(held),      32'(0));
      check("rst.pulses", 32'({rise_pulse, fall_pulse, held_pulse}), 32'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Directed: clean step on ch0 must take exactly SYNC+STABLE edges, one-cycle rise pulse.
      bouncy_in[0] = 1'b1;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!clean_out[0] && lat < 40);
      check("lat.edges", 32'(lat), 32'(SYNC + STABLE));
      check("lat.rise",  32'(rise_pulse), 32'(1));
      @(posedge clk);
      #1;
      check("lat.rise_off", 32'(rise_pulse), 32'(0));
      check("lat.clean_hold", 32'(clean_out), 32'(1));

      // Reset mid-state: outputs return to reset values without a clock edge.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst.clean", 32'(clean_out), 32'(0));
      check("arst.rise",  32'(rise_pulse | fall_pulse), 32'(0));
      bouncy_in = '0;
      model_reset();
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b1;

      level = '0;
      for (int c = 0; c < CH; c++) remaining[c] = $urandom_range(1, 30);

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         check_outputs("rand");
         for (int c = 0; c < CH; c++) begin
            if (remaining[c] == 0) begin
               level[c]     = ~level[c];
               remaining[c] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 9)
                                                          : $urandom_range(10, 45);
            end
            remaining[c]--;
         end
         bouncy_in = level;
         if (cyc == 700 || cyc == 1500 || cyc == 2300) begin
            #2;
            rst_n = 1'b0;
            model_reset();
            #1;
            check_outputs("arst");
         end
         if (cyc == 703 || cyc == 1503 || cyc == 2303) begin
            #2;
            rst_n = 1'b1;
         end
         @(posedge clk);
         model_edge();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
